wash_status_monitor: RTL and testbench
======================================

// Module: wash_status_monitor
// PURPOSE
//  Downstream consumer of the washing-machine controller's stage[2:0] output.
//  Tracks time spent in each stage, holds the door lock while the drum is active,
//  raises a sticky fault on stage timeout or illegal encoding, and sounds a
//  completion buzzer. Sits between the controller and the front-panel/door hardware.
// PARAMETERS
//  TICK_DIV       10   clk cycles per timing tick (prescaler period, >=2)
//  STAGE_TIMEOUT  50   ticks allowed in any active stage before fault
//  UNLOCK_DELAY   4    ticks door stays locked after reaching DONE/IDLE
//  BUZZ_TICKS     8    ticks of completion buzz pattern (1 tick on, 1 tick off)
// PORTS
//  clk            in   1   system clock, rising edge
//  rst            in   1   reset, asynchronous, active-low
//  supply         in   1   mains present; 0 freezes all timing
//  stage          in   3   controller stage code (encoding below)
//  stage_changed  out  1   1-cycle pulse on accepted stage change
//  elapsed        out  16  ticks spent in current stage, saturating
//  door_lock      out  1   1 = door solenoid locked
//  buzzer         out  1   buzzer drive
//  fault          out  1   sticky fault flag
//  done           out  1   registered copy of (stage == DONE)
// BEHAVIOUR
//  Stage codes: 0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 DONE; 6,7 illegal.
//  Active stages: FILL..SPIN.
//  Reset (rst=0, async): all outputs 0, stage_q=IDLE, prescaler=0, lock FSM UNLOCKED,
//   buzz FSM QUIET. Reset mid-operation aborts everything immediately.
//  stage_q registers stage every clk while supply=1; held while supply=0.
//  stage_changed: asserted 1 cycle after stage!=stage_q is sampled with supply=1.
//  Tick: prescaler counts 0..TICK_DIV-1 only when supply=1; tick pulse at wrap;
//   count frozen (not cleared) while supply=0.
//  elapsed: cleared to 0 on stage change; +1 per tick; saturates at 16'hFFFF.
//   Stage change and tick in same cycle -> elapsed=0 (change wins).
//  fault: set when stage_q active and elapsed reaches STAGE_TIMEOUT, or one cycle
//   after an illegal code is sampled. Sticky; cleared only when stage_q==IDLE.
//  Lock FSM: UNLOCKED -> LOCKED when stage_q active; LOCKED -> RELEASE_WAIT when
//   stage_q is DONE or IDLE; RELEASE_WAIT counts UNLOCK_DELAY ticks -> UNLOCKED;
//   re-entry to an active stage in RELEASE_WAIT -> LOCKED. door_lock=1 in LOCKED and
//   RELEASE_WAIT, and forced 1 whenever fault=1. supply=0 holds state and lock.
//  Buzz FSM: QUIET -> BUZZ on stage change into DONE; buzzer=1 on even tick index,
//   0 on odd, for BUZZ_TICKS ticks, then QUIET. Leaving DONE early -> QUIET.
//   fault=1 -> buzzer=1 continuous (overrides pattern). supply=0 -> buzzer forced 0,
//   pattern position frozen.
//  done: registered, 1-cycle latency from stage_q.
// STRUCTURE
//  Package wm_pkg: stage code localparams (shared with washing_machine), lock/buzz
//   FSM state encodings, function is_active(stage).
//  Sub-module wm_tick_gen: enable-gated prescaler, param TICK_DIV, outputs tick pulse.
//  Top: stage register/edge detect, elapsed counter, fault logic, two FSMs.
// TESTING
//  Reset: rst=0 with stage=2,supply=1 -> all outputs 0; release -> lock=1 within 2 clks.
//  Normal run 0->1->2->3->4->5, 15 ticks each -> 5 change pulses, elapsed resets each
//   stage, no fault, door_lock drops 4 ticks (40 clks) after DONE, buzzer 4 pulses.
//  Timeout: hold stage=2 for 50 ticks -> fault=1 at tick 50, buzzer=1, lock=1;
//   stage=0 -> fault clears, lock releases after 4 ticks.
//  Supply loss: supply=0 at elapsed=7 in WASH for 200 clks -> elapsed stays 7,
//   lock stays 1, buzzer 0, no change pulse; supply=1 -> counting resumes at 7.
//  Illegal code: stage=3'b110 one cycle -> fault=1 next cycle, sticky until IDLE.
//  Async reset mid-SPIN between clk edges -> outputs 0 before next clk edge.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller and its status monitor:
// stage codes, monitor FSM encodings and stage classification helpers.
package wm_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_WASH  = 3'd2;
  localparam logic [2:0] ST_RINSE = 3'd3;
  localparam logic [2:0] ST_SPIN  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [1:0] {
    LK_UNLOCKED     = 2'd0,
    LK_LOCKED       = 2'd1,
    LK_RELEASE_WAIT = 2'd2
  } lock_state_e;

  typedef enum logic {
    BZ_QUIET = 1'b0,
    BZ_BUZZ  = 1'b1
  } buzz_state_e;

  // Drum-active stages: FILL through SPIN.
  function automatic logic is_active(input logic [2:0] s);
    return (s >= ST_FILL) && (s <= ST_SPIN);
  endfunction

  // Codes 6 and 7 are never produced by a healthy controller.
  function automatic logic is_legal(input logic [2:0] s);
    return s <= ST_DONE;
  endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Enable-gated prescaler. Counts 0..TICK_DIV-1 while en=1 and emits a one-cycle
// tick on the wrap edge. The count is frozen (not cleared) while en=0, so a
// supply dropout does not lose the partial tick period.
module wm_tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  // Prescaler count, wraps on tick, holds while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wash_status_monitor.sv
// Washing-machine status monitor: follows the controller stage code, times each
// stage, drives the door lock and completion buzzer, and flags timeouts or
// illegal codes with a sticky fault.
//
// Lock FSM
//   state        | meaning
//   UNLOCKED     | door free, drum idle
//   LOCKED       | drum in an active stage
//   RELEASE_WAIT | drum stopped, counting UNLOCK_DELAY ticks before release
// Buzz FSM
//   state        | meaning
//   QUIET        | buzzer off (unless fault)
//   BUZZ         | completion pattern, on for even tick index, off for odd
module wash_status_monitor
  import wm_pkg::*;
#(
  parameter int TICK_DIV      = 10,
  parameter int STAGE_TIMEOUT = 50,
  parameter int UNLOCK_DELAY  = 4,
  parameter int BUZZ_TICKS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        supply,
  input  logic [2:0]  stage,
  output logic        stage_changed,
  output logic [15:0] elapsed,
  output logic        door_lock,
  output logic        buzzer,
  output logic        fault,
  output logic        done
);

  localparam int RW = $clog2(UNLOCK_DELAY + 1);
  localparam int BW = $clog2(BUZZ_TICKS + 1);
  localparam logic [RW-1:0] REL_LAST  = RW'(UNLOCK_DELAY - 1);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_TICKS - 1);
  localparam logic [15:0]   TIMEOUT   = 16'(STAGE_TIMEOUT);

  logic [2:0]  stage_q;
  logic        stage_changed_q;
  logic [15:0] elapsed_q, elapsed_d;
  logic        fault_q, fault_d;
  logic        done_q;
  logic        chg;
  logic        tick;

  lock_state_e   lock_q;
  logic [RW-1:0] rel_cnt_q;
  logic          door_lock_q;

  buzz_state_e   buzz_q;
  logic [BW-1:0] bidx_q;
  logic          buzzer_q;

  wm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (supply),
    .tick (tick)
  );

  assign chg = supply && (stage != stage_q);

  // Elapsed counter and sticky fault next-state; everything freezes without supply.
  always_comb begin
    elapsed_d = elapsed_q;
    if (chg) begin
      elapsed_d = '0;
    end else if (tick && (elapsed_q != 16'hFFFF)) begin
      elapsed_d = elapsed_q + 16'd1;
    end

    fault_d = fault_q;
    if (supply) begin
      if (!is_legal(stage) || (is_active(stage_q) && (elapsed_d >= TIMEOUT))) begin
        fault_d = 1'b1;
      end else if (stage_q == ST_IDLE) begin
        fault_d = 1'b0;
      end
    end
  end

  // Stage register, change pulse, elapsed, fault and done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q         <= ST_IDLE;
      stage_changed_q <= 1'b0;
      elapsed_q       <= '0;
      fault_q         <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      if (supply) begin
        stage_q <= stage;
      end
      stage_changed_q <= chg;
      elapsed_q       <= elapsed_d;
      fault_q         <= fault_d;
      done_q          <= (stage_q == ST_DONE);
    end
  end

  // Door-lock FSM with registered lock drive; fault always holds the door shut.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q      <= LK_UNLOCKED;
      rel_cnt_q   <= '0;
      door_lock_q <= 1'b0;
    end else if (supply) begin
      case (lock_q)
        LK_UNLOCKED: begin
          if (is_active(stage_q)) begin
            lock_q      <= LK_LOCKED;
            door_lock_q <= 1'b1;
          end else begin
            door_lock_q <= fault_d;
          end
        end
        LK_LOCKED: begin
          door_lock_q <= 1'b1;
          if ((stage_q == ST_DONE) || (stage_q == ST_IDLE)) begin
            lock_q    <= LK_RELEASE_WAIT;
            rel_cnt_q <= '0;
          end
        end
        LK_RELEASE_WAIT: begin
          door_lock_q <= 1'b1;
          if (is_active(stage_q)) begin
            lock_q <= LK_LOCKED;
          end else if (tick) begin
            if (rel_cnt_q == REL_LAST) begin
              lock_q      <= LK_UNLOCKED;
              door_lock_q <= fault_d;
            end else begin
              rel_cnt_q <= rel_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          lock_q      <= LK_UNLOCKED;
          door_lock_q <= fault_d;
        end
      endcase
    end
  end

  // Completion-buzz FSM; no supply silences the buzzer (even under fault) and
  // freezes the pattern position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buzz_q   <= BZ_QUIET;
      bidx_q   <= '0;
      buzzer_q <= 1'b0;
    end else if (!supply) begin
      buzzer_q <= 1'b0;
    end else if (chg) begin
      if (stage == ST_DONE) begin
        buzz_q   <= BZ_BUZZ;
        bidx_q   <= '0;
        buzzer_q <= 1'b1;
      end else begin
        buzz_q   <= BZ_QUIET;
        buzzer_q <= fault_d;
      end
    end else begin
      case (buzz_q)
        BZ_BUZZ: begin
          if (tick) begin
            if (bidx_q == BUZZ_LAST) begin
              buzz_q   <= BZ_QUIET;
              buzzer_q <= fault_d;
            end else begin
              bidx_q   <= bidx_q + 1'b1;
              buzzer_q <= fault_d | bidx_q[0];
            end
          end else begin
            buzzer_q <= fault_d | ~bidx_q[0];
          end
        end
        default: begin
          buzz_q   <= BZ_QUIET;
          buzzer_q <= fault_d;
        end
      endcase
    end
  end

  assign stage_changed = stage_changed_q;
  assign elapsed       = elapsed_q;
  assign door_lock     = door_lock_q;
  assign buzzer        = buzzer_q;
  assign fault         = fault_q;
  assign done          = done_q;

endmodule

// File: tb/tb_wash_status_monitor.sv
// Directed bench for wash_status_monitor with default parameters
// (TICK_DIV=10, STAGE_TIMEOUT=50, UNLOCK_DELAY=4, BUZZ_TICKS=8).
// Inputs change and outputs are sampled on the falling clock edge. After each
// reset release, P counts rising edges; ticks land on P = 10, 20, 30, ...
module tb_wash_status_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        supply = 1'b1;
  logic [2:0]  stage = 3'd2;
  logic        stage_changed;
  logic [15:0] elapsed;
  logic        door_lock;
  logic        buzzer;
  logic        fault;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  wash_status_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .supply        (supply),
    .stage         (stage),
    .stage_changed (stage_changed),
    .elapsed       (elapsed),
    .door_lock     (door_lock),
    .buzzer        (buzzer),
    .fault         (fault),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stage = 3'd0;
    supply = 1'b1;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    int rises;
    int drop_at;
    int n_bad_chg, n_bad_el, n_bad_lock, n_bad_buzz;
    logic prev_buzz;

    // Reset held with stage=WASH, supply on.
    #1 rst = 1'b0;
    step(3);
    check("rst_stage_changed", stage_changed, 0);
    check("rst_elapsed", elapsed, 0);
    check("rst_door_lock", door_lock, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_fault", fault, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    step(1);
    check("rel_change_pulse", stage_changed, 1);
    check("rel_lock_clk1", door_lock, 0);
    step(1);
    check("rel_lock_clk2", door_lock, 1);
    check("rel_pulse_end", stage_changed, 0);

    // Normal run: 15 ticks per active stage, then DONE.
    do_reset();
    for (int s = 1; s <= 4; s++) begin
      stage = 3'(s);
      step(1);
      check($sformatf("run_chg_s%0d", s), stage_changed, 1);
      check($sformatf("run_el0_s%0d", s), elapsed, 0);
      step(149);
      check($sformatf("run_el15_s%0d", s), elapsed, 15);
      check($sformatf("run_nofault_s%0d", s), fault, 0);
      check($sformatf("run_lock_s%0d", s), door_lock, 1);
    end
    stage = 3'd5;
    rises = 0;
    drop_at = -1;
    prev_buzz = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (i == 0) begin
        check("done_chg", stage_changed, 1);
        check("done_lat0", done, 0);
      end
      if (i == 1) check("done_lat1", done, 1);
      if (buzzer && !prev_buzz) rises++;
      prev_buzz = buzzer;
      if (!door_lock && drop_at < 0) drop_at = i;
    end
    check("buzz_pulses", rises, 4);
    check("buzz_end", buzzer, 0);
    check("unlock_delay", drop_at, 39);
    check("run_fault_end", fault, 0);

    // Stage timeout in WASH.
    do_reset();
    stage = 3'd2;
    step(499);
    check("to_el49", elapsed, 49);
    check("to_nofault49", fault, 0);
    step(1);
    check("to_el50", elapsed, 50);
    check("to_fault", fault, 1);
    check("to_buzz", buzzer, 1);
    check("to_lock", door_lock, 1);
    step(10);
    stage = 3'd0;
    step(2);
    check("to_fault_clr", fault, 0);
    check("to_buzz_clr", buzzer, 0);
    check("to_lock_hold", door_lock, 1);
    step(37);
    check("to_lock_549", door_lock, 1);
    step(1);
    check("to_lock_550", door_lock, 0);

    // Supply loss at elapsed=7 in WASH, stage input wiggled meanwhile.
    do_reset();
    stage = 3'd2;
    step(75);
    check("sup_el7", elapsed, 7);
    supply = 1'b0;
    stage = 3'd3;
    n_bad_chg = 0; n_bad_el = 0; n_bad_lock = 0; n_bad_buzz = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (stage_changed !== 1'b0) n_bad_chg++;
      if (elapsed !== 16'd7) n_bad_el++;
      if (door_lock !== 1'b1) n_bad_lock++;
      if (buzzer !== 1'b0) n_bad_buzz++;
    end
    check("sup_no_chg", n_bad_chg, 0);
    check("sup_el_frozen", n_bad_el, 0);
    check("sup_lock_held", n_bad_lock, 0);
    check("sup_buzz_off", n_bad_buzz, 0);
    stage = 3'd2;
    supply = 1'b1;
    step(4);
    check("sup_resume_pre", elapsed, 7);
    step(1);
    check("sup_resume_tick", elapsed, 8);
    check("sup_resume_nochg", stage_changed, 0);

    // Illegal code for one cycle.
    stage = 3'd6;
    step(1);
    check("ill_fault", fault, 1);
    stage = 3'd2;
    step(5);
    check("ill_sticky", fault, 1);
    check("ill_buzz", buzzer, 1);
    check("ill_lock", door_lock, 1);
    stage = 3'd0;
    step(1);
    check("ill_hold", fault, 1);
    step(1);
    check("ill_clr", fault, 0);

    // Stage change coinciding with a tick: change wins.
    do_reset();
    stage = 3'd1;
    step(19);
    check("coin_el1", elapsed, 1);
    stage = 3'd2;
    step(1);
    check("coin_el0", elapsed, 0);
    check("coin_chg", stage_changed, 1);

    // Async reset in the middle of SPIN, between clock edges.
    stage = 3'd4;
    step(30);
    check("spin_el3", elapsed, 3);
    check("spin_lock", door_lock, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_lock", door_lock, 0);
    check("arst_elapsed", elapsed, 0);
    check("arst_chg", stage_changed, 0);
    check("arst_fault", fault, 0);
    check("arst_buzz", buzzer, 0);
    check("arst_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
